// File: rtl/warp_issue_scheduler.sv
// Warp issue scheduler: one pending instruction per warp, round-robin
// selection into a valid/ready output register, per-warp busy tracking.
module warp_issue_scheduler #(
    parameter int NUM_WARPS = 8,
    parameter int WARP_ID_W = 5,
    parameter int INSTR_W   = 32,
    parameter int ALU_LAT   = 4,
    parameter int FPU_LAT   = 8,
    parameter int BR_LAT    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ld_valid,
    input  logic [WARP_ID_W-1:0] ld_warp_id,
    input  logic [INSTR_W-1:0]   ld_instr,
    output logic                 ld_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WARP_ID_W-1:0] out_warp_id,
    output logic [INSTR_W-1:0]   out_instr,
    output logic [1:0]           out_class,
    output logic [15:0]          issue_count,
    output logic [15:0]          idle_cycles
);

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_FPU = 2'd1;
    localparam logic [1:0] CLS_BR  = 2'd2;

    logic [NUM_WARPS-1:0] slot_valid;
    logic [INSTR_W-1:0]   slot_instr [NUM_WARPS];
    logic [3:0]           busy [NUM_WARPS];
    logic [WARP_ID_W-1:0] rr_ptr;

    logic [NUM_WARPS-1:0] ld_hit;
    logic [NUM_WARPS-1:0] load_en;
    logic [NUM_WARPS-1:0] eligible;
    logic [NUM_WARPS-1:0] winner_oh;
    logic [NUM_WARPS-1:0] take;
    logic                 fire;
    logic                 refill;
    logic                 found;
    logic [WARP_ID_W-1:0] winner;
    logic [WARP_ID_W-1:0] winner_next;
    logic [INSTR_W-1:0]   winner_instr;

    function automatic logic [1:0] classify(input logic [INSTR_W-1:0] instr);
        logic [1:0] cls;
        cls = CLS_ALU;
        if (instr[31:28] == 4'h1)
            cls = CLS_FPU;
        else if (instr[7:0] == 8'hBA)
            cls = CLS_BR;
        return cls;
    endfunction

    function automatic logic [3:0] latency(input logic [1:0] cls);
        logic [3:0] lat;
        unique case (cls)
            CLS_FPU: lat = 4'(FPU_LAT);
            CLS_BR:  lat = 4'(BR_LAT);
            default: lat = 4'(ALU_LAT);
        endcase
        return lat;
    endfunction

    // Out-of-range warp ids decode to no slot, so ld_ready stays low.
    always_comb begin
        ld_hit = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            ld_hit[w] = (ld_warp_id == WARP_ID_W'(w));
    end

    assign ld_ready = |(ld_hit & ~slot_valid);
    assign load_en  = ld_valid ? (ld_hit & ~slot_valid) : '0;
    assign fire     = out_valid && out_ready;
    assign refill   = !out_valid || fire;

    always_comb begin
        eligible = '0;
        for (int w = 0; w < NUM_WARPS; w++)
            eligible[w] = slot_valid[w] && (busy[w] == 4'd0) &&
                          !(out_valid && out_warp_id == WARP_ID_W'(w));
    end

    always_comb begin
        int idx;
        found        = 1'b0;
        winner       = '0;
        winner_oh    = '0;
        winner_instr = '0;
        idx          = 0;
        for (int k = 0; k < NUM_WARPS; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_WARPS;
            if (!found && eligible[idx]) begin
                found          = 1'b1;
                winner         = WARP_ID_W'(idx);
                winner_oh[idx] = 1'b1;
                winner_instr   = slot_instr[idx];
            end
        end
    end

    assign winner_next = (int'(winner) == NUM_WARPS - 1) ? '0
                                                         : winner + 1'b1;
    assign take = (refill && found) ? winner_oh : '0;

    always_ff @(posedge clk) begin
        for (int w = 0; w < NUM_WARPS; w++)
            if (load_en[w])
                slot_instr[w] <= ld_instr;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_valid  <= '0;
            rr_ptr      <= '0;
            out_valid   <= 1'b0;
            out_warp_id <= '0;
            out_instr   <= '0;
            out_class   <= CLS_ALU;
            issue_count <= '0;
            idle_cycles <= '0;
            for (int w = 0; w < NUM_WARPS; w++)
                busy[w] <= 4'd0;
        end else begin
            if (fire)
                issue_count <= issue_count + 16'd1;
            if (!out_valid && |slot_valid)
                idle_cycles <= idle_cycles + 16'd1;

            for (int w = 0; w < NUM_WARPS; w++) begin
                if (fire && out_warp_id == WARP_ID_W'(w))
                    busy[w] <= latency(out_class);
                else if (busy[w] != 4'd0)
                    busy[w] <= busy[w] - 4'd1;
            end

            // A slot taken this edge cannot also be loaded: it was not ready.
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (take[w])
                    slot_valid[w] <= 1'b0;
                else if (load_en[w])
                    slot_valid[w] <= 1'b1;
            end

            if (refill) begin
                if (found) begin
                    out_valid   <= 1'b1;
                    out_warp_id <= winner;
                    out_instr   <= winner_instr;
                    out_class   <= classify(winner_instr);
                    rr_ptr      <= winner_next;
                end else begin
                    out_valid   <= 1'b0;
                end
            end
        end
    end

endmodule
